txuart_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter among NREQ byte producers. Each requester gets a one-byte holding buffer with the same wr/busy handshake the transmitter uses. The arbiter drives the transmitter's i_wr/i_data and watches its o_busy. It can also prefix each payload byte with a channel tag byte. It sits between the per-channel byte sources and the single transmitter driving the UART pin.

---
 rtl/txuart_arbiter.sv | 94 +++++++++
 tb/tb_txuart_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txuart_arbiter.sv
// txuart_arbiter: round-robin sharing of one UART transmitter among NREQ one-byte holding buffers,
// with an optional channel tag byte sent ahead of each payload.
module txuart_arbiter #(
    parameter int         NREQ     = 4,
    parameter bit         OPT_TAG  = 1'b0,
    parameter logic [7:0] TAG_BASE = 8'hF8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NREQ-1:0]   i_req_wr,
    input  logic [8*NREQ-1:0] i_req_data,
    output logic [NREQ-1:0]   o_req_busy,
    output logic              o_tx_wr,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    output logic [NREQ-1:0]   o_grant,
    output logic [15:0]       o_sent_count
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;
    state_t          state_q;
    logic [NREQ-1:0] full_q, full_d, busy_q, grant_q, clr;
    logic [7:0]      buf_q [NREQ];
    logic [IW-1:0]   ptr_q, g_q, win, c;
    logic            found, accept, tx_wr_q;
    logic [7:0]      tx_data_q;
    logic [15:0]     cnt_q;

    assign accept = tx_wr_q && !i_tx_busy;
    assign clr    = (state_q == DATA && accept) ? NREQ'(1) << g_q : '0;
    assign full_d = (full_q | (i_req_wr & ~busy_q)) & ~clr;

    // first full buffer after the last grant, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        c     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            c = IW'((int'(ptr_q) + i) % NREQ);
            if (!found && full_q[c]) begin
                found = 1'b1;
                win   = c;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            full_q    <= '0;
            busy_q    <= '0;
            grant_q   <= '0;
            ptr_q     <= IW'(NREQ - 1);
            g_q       <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            cnt_q     <= 16'h0000;
            for (int k = 0; k < NREQ; k++) buf_q[k] <= 8'h00;
        end else begin
            full_q <= full_d;
            // busy lags the full flag by one cycle on release so a write on the freeing cycle is refused
            busy_q <= full_d | full_q;
            for (int k = 0; k < NREQ; k++)
                if (i_req_wr[k] && !busy_q[k]) buf_q[k] <= i_req_data[8*k +: 8];
            case (state_q)
                IDLE: if (found) begin
                    g_q       <= win;
                    ptr_q     <= win;
                    grant_q   <= NREQ'(1) << win;
                    tx_wr_q   <= 1'b1;
                    tx_data_q <= OPT_TAG ? {TAG_BASE[7:3], 3'(win)} : buf_q[win];
                    state_q   <= OPT_TAG ? TAG : DATA;
                end
                TAG: if (accept) begin
                    tx_data_q <= buf_q[g_q];
                    state_q   <= DATA;
                end
                DATA: if (accept) begin
                    tx_wr_q <= 1'b0;
                    grant_q <= '0;
                    cnt_q   <= cnt_q + 16'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_req_busy   = busy_q;
    assign o_tx_wr      = tx_wr_q;
    assign o_tx_data    = tx_data_q;
    assign o_grant      = grant_q;
    assign o_sent_count = cnt_q;
endmodule

// File: tb/tb_txuart_arbiter.sv
// tb_txuart_arbiter: two arbiters (untagged and tagged) driven by random producers against a behavioural
// transmitter; observed byte streams are compared with round-robin order derived from the channel set.
module tb_txuart_arbiter;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req_wr   [2];
    logic [31:0] req_data [2];
    logic [3:0]  busy     [2];
    logic        tx_wr    [2];
    logic [7:0]  tx_data  [2];
    logic        tx_busy  [2];
    logic [3:0]  grant    [2];
    logic [15:0] cnt      [2];

    int bc   [2] = '{0, 0};
    int tlen [2] = '{1, 1};
    int viol [2] = '{0, 0};
    logic pw [2] = '{1'b0, 1'b0};
    logic pb [2] = '{1'b0, 1'b0};
    logic pr [2] = '{1'b0, 1'b0};
    logic [7:0] pd [2] = '{8'h00, 8'h00};
    logic [7:0] rx0[$], rx1[$];
    logic [3:0] g0[$], g1[$];
    int n_checks = 0, n_pass = 0;

    txuart_arbiter #(.NREQ(4), .OPT_TAG(1'b0), .TAG_BASE(8'hF8)) u0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_req_wr(req_wr[0]), .i_req_data(req_data[0]),
        .o_req_busy(busy[0]), .o_tx_wr(tx_wr[0]), .o_tx_data(tx_data[0]), .i_tx_busy(tx_busy[0]),
        .o_grant(grant[0]), .o_sent_count(cnt[0]));
    txuart_arbiter #(.NREQ(4), .OPT_TAG(1'b1), .TAG_BASE(8'hF8)) u1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_req_wr(req_wr[1]), .i_req_data(req_data[1]),
        .o_req_busy(busy[1]), .o_tx_wr(tx_wr[1]), .o_tx_data(tx_data[1]), .i_tx_busy(tx_busy[1]),
        .o_grant(grant[1]), .o_sent_count(cnt[1]));

    assign tx_busy[0] = bc[0] != 0;
    assign tx_busy[1] = bc[1] != 0;

    // transmitter stand-in: busy for tlen cycles after each accepted byte; logs bytes and grants,
    // and counts handshake breaks (request dropped or changed while waiting)
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_wr[d] && !tx_busy[d]) begin
                if (d == 0) begin rx0.push_back(tx_data[d]); g0.push_back(grant[d]); end
                else begin rx1.push_back(tx_data[d]); g1.push_back(grant[d]); end
                bc[d] <= tlen[d];
            end else if (bc[d] != 0) bc[d] <= bc[d] - 1;
            if (pw[d] && pb[d] && pr[d] && rst_n && (!tx_wr[d] || tx_data[d] !== pd[d])) viol[d] <= viol[d] + 1;
            pw[d] <= tx_wr[d];
            pb[d] <= tx_busy[d];
            pd[d] <= tx_data[d];
            pr[d] <= rst_n;
        end
    end

    function automatic int rxn(int d);
        return d == 0 ? rx0.size() : rx1.size();
    endfunction
    function automatic logic [7:0] rxb(int d, int i);
        return d == 0 ? rx0[i] : rx1[i];
    endfunction
    function automatic logic [3:0] rxg(int d, int i);
        return d == 0 ? g0[i] : g1[i];
    endfunction
    task automatic clr_log(int d);
        if (d == 0) begin rx0.delete(); g0.delete(); end
        else begin rx1.delete(); g1.delete(); end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_wr[0] = '0; req_wr[1] = '0;
        req_data[0] = '0; req_data[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(int d);
        for (int t = 0; t < 200 && bc[d] != 0; t++) @(negedge clk);
        if (bc[d] != 0) begin
            n_checks++;
            $display("FAIL wait_idle d%0d: tx_busy=1 required 0", d);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_wr[0] = '0; req_wr[1] = '0;
        req_data[0] = '0; req_data[1] = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({tx_wr[d], tx_data[d], grant[d], busy[d], cnt[d]} !== 33'h0)
                $display("FAIL reset d%0d: wr=%b data=%h grant=%b busy=%b cnt=%0d required all 0",
                         d, tx_wr[d], tx_data[d], grant[d], busy[d], cnt[d]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        do_reset;
        tlen[0] = 3;
        wait_idle(0);
        clr_log(0);
        req_wr[0] = 4'b0100; req_data[0] = 32'h00A50000;
        @(negedge clk);
        req_wr[0] = '0;
        n_checks++;
        if ({busy[0], tx_wr[0]} !== 5'b0100_0) $display("FAIL single_c1: busy=%b wr=%b required 0100 0", busy[0], tx_wr[0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({tx_wr[0], tx_data[0], grant[0]} !== {1'b1, 8'hA5, 4'b0100})
            $display("FAIL single_c2: wr=%b data=%h grant=%b required 1 a5 0100", tx_wr[0], tx_data[0], grant[0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({tx_wr[0], cnt[0], busy[0], grant[0]} !== {1'b0, 16'd1, 4'b0100, 4'b0000})
            $display("FAIL single_c3: wr=%b cnt=%0d busy=%b grant=%b required 0 1 0100 0000", tx_wr[0], cnt[0], busy[0], grant[0]);
        else n_pass++;
        req_wr[0] = 4'b0100; req_data[0] = 32'h00EE0000;
        @(negedge clk);
        req_wr[0] = '0;
        n_checks++;
        if (busy[0] !== 4'b0000) $display("FAIL single_c4: busy=%b required 0000", busy[0]);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (cnt[0] !== 16'd1 || rxn(0) != 1) $display("FAIL single_ignored: cnt=%0d bytes=%0d required 1 1", cnt[0], rxn(0));
        else n_pass++;
        if (rxn(0) > 0) begin
            n_checks++;
            if (rxb(0, 0) !== 8'hA5) $display("FAIL single_byte: got %h required a5", rxb(0, 0));
            else n_pass++;
        end
    endtask

    task automatic test_all_at_once;
        int base;
        do_reset;
        tlen[0] = $urandom_range(1, 4);
        wait_idle(0);
        clr_log(0);
        base = viol[0];
        req_wr[0] = 4'hF; req_data[0] = 32'h13121110;
        @(negedge clk);
        req_wr[0] = '0;
        for (int t = 0; t < 300 && cnt[0] < 4; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        n_checks++;
        if (rxn(0) != 4) $display("FAIL all_count: got %0d bytes required 4", rxn(0));
        else n_pass++;
        for (int i = 0; i < 4 && i < rxn(0); i++) begin
            n_checks++;
            if ({rxb(0, i), rxg(0, i)} !== {8'h10 + 8'(i), 4'(1 << i)})
                $display("FAIL all_order[%0d]: byte=%h grant=%b required %h %b", i, rxb(0, i), rxg(0, i), 8'h10 + 8'(i), 4'(1 << i));
            else n_pass++;
        end
        n_checks++;
        if (busy[0] !== 4'h0 || viol[0] != base) $display("FAIL all_end: busy=%b hs_breaks=%0d required 0000 0", busy[0], viol[0] - base);
        else n_pass++;
    endtask

    // producers write whenever their buffer is free (with probability prob%); with prob=100 the
    // expected grant order is strict rotation over the channels in mask, lowest first after reset
    task automatic test_saturate(int d, logic [3:0] mask, int n, int prob);
        logic [7:0]  wd [4][16];
        int          wn [4], seen [4], lst [4];
        int          m, tot, base, ch, e;
        logic [3:0]  w, gr;
        logic [31:0] dat;
        logic [7:0]  b;
        do_reset;
        clr_log(d);
        base = viol[d];
        m = 0;
        for (int k = 0; k < 4; k++) begin
            wn[k] = 0; seen[k] = 0;
            if (mask[k]) begin lst[m] = k; m++; end
        end
        tot = m * n;
        for (int t = 0; t < 3000 && cnt[d] < 16'(tot); t++) begin
            tlen[d] = $urandom_range(1, 4);
            w = '0; dat = '0;
            for (int k = 0; k < 4; k++)
                if (mask[k] && !busy[d][k] && wn[k] < n && $urandom_range(0, 99) < prob) begin
                    b = 8'($urandom);
                    wd[k][wn[k]] = b;
                    dat[8*k +: 8] = b;
                    w[k] = 1'b1;
                    wn[k]++;
                end
            req_wr[d] = w; req_data[d] = dat;
            @(negedge clk);
        end
        req_wr[d] = '0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (cnt[d] !== 16'(tot) || rxn(d) != tot * (d + 1))
            $display("FAIL sat_count d%0d mask %b: cnt=%0d bytes=%0d required %0d %0d", d, mask, cnt[d], rxn(d), tot, tot * (d + 1));
        else n_pass++;
        for (int i = 0; i < tot && (d + 1) * i + d < rxn(d); i++) begin
            e = (d + 1) * i + d;
            gr = rxg(d, e);
            ch = 0;
            for (int j = 0; j < 4; j++) if (gr[j]) ch = j;
            n_checks++;
            if (!$onehot(gr) || (prob == 100 && ch != lst[i % m]))
                $display("FAIL sat_grant d%0d [%0d]: grant=%b required channel %0d", d, i, gr, lst[i % m]);
            else n_pass++;
            if (d == 1) begin
                n_checks++;
                if ({rxb(d, e - 1), rxg(d, e - 1)} !== {8'hF8 + 8'(ch), gr})
                    $display("FAIL sat_tag [%0d]: tag=%h grant=%b required %h %b", i, rxb(d, e - 1), rxg(d, e - 1), 8'hF8 + 8'(ch), gr);
                else n_pass++;
            end
            if (seen[ch] < wn[ch]) begin
                n_checks++;
                if (rxb(d, e) !== wd[ch][seen[ch]])
                    $display("FAIL sat_data d%0d [%0d] ch%0d: got %h required %h", d, i, ch, rxb(d, e), wd[ch][seen[ch]]);
                else n_pass++;
                seen[ch]++;
            end
        end
        n_checks++;
        if (busy[d] !== 4'h0 || viol[d] != base)
            $display("FAIL sat_end d%0d: busy=%b hs_breaks=%0d required 0000 0", d, busy[d], viol[d] - base);
        else n_pass++;
    endtask

    task automatic test_tag;
        do_reset;
        tlen[1] = 3;
        wait_idle(1);
        clr_log(1);
        req_wr[1] = 4'b0010; req_data[1] = 32'h00003C00;
        @(negedge clk);
        req_wr[1] = '0;
        @(negedge clk);
        n_checks++;
        if ({tx_wr[1], tx_data[1], grant[1]} !== {1'b1, 8'hF9, 4'b0010})
            $display("FAIL tag_c2: wr=%b data=%h grant=%b required 1 f9 0010", tx_wr[1], tx_data[1], grant[1]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({tx_wr[1], tx_data[1], busy[1]} !== {1'b1, 8'h3C, 4'b0010})
            $display("FAIL tag_c3: wr=%b data=%h busy=%b required 1 3c 0010", tx_wr[1], tx_data[1], busy[1]);
        else n_pass++;
        for (int t = 0; t < 50 && cnt[1] == 0; t++) begin
            n_checks++;
            if (busy[1] !== 4'b0010) $display("FAIL tag_busy_hold: busy=%b required 0010", busy[1]);
            else n_pass++;
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if ({busy[1], cnt[1]} !== {4'b0000, 16'd1}) $display("FAIL tag_end: busy=%b cnt=%0d required 0000 1", busy[1], cnt[1]);
        else n_pass++;
        n_checks++;
        if (rxn(1) != 2) $display("FAIL tag_bytes: got %0d bytes required 2", rxn(1));
        else if ({rxb(1, 0), rxb(1, 1)} !== 16'hF93C) $display("FAIL tag_stream: got %h %h required f9 3c", rxb(1, 0), rxb(1, 1));
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int base;
        do_reset;
        tlen[0] = 12;
        wait_idle(0);
        req_wr[0] = 4'b0010; req_data[0] = 32'h00001100;
        @(negedge clk);
        req_wr[0] = '0;
        repeat (2) @(negedge clk);
        req_wr[0] = 4'b0001; req_data[0] = 32'h00000077;
        @(negedge clk);
        req_wr[0] = '0;
        @(negedge clk);
        n_checks++;
        if ({tx_wr[0], tx_data[0], tx_busy[0]} !== {1'b1, 8'h77, 1'b1})
            $display("FAIL rst_pre: wr=%b data=%h txbusy=%b required 1 77 1", tx_wr[0], tx_data[0], tx_busy[0]);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_wr[0], tx_data[0], grant[0], busy[0], cnt[0]} !== 33'h0)
            $display("FAIL rst_async: wr=%b data=%h grant=%b busy=%b cnt=%0d required all 0", tx_wr[0], tx_data[0], grant[0], busy[0], cnt[0]);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr_log(0);
        base = viol[0];
        req_wr[0] = 4'b0001; req_data[0] = 32'h00000055;
        @(negedge clk);
        req_wr[0] = '0;
        @(negedge clk);
        n_checks++;
        if ({tx_wr[0], tx_data[0], tx_busy[0]} !== {1'b1, 8'h55, 1'b1})
            $display("FAIL rst_wait: wr=%b data=%h txbusy=%b required 1 55 1", tx_wr[0], tx_data[0], tx_busy[0]);
        else n_pass++;
        for (int t = 0; t < 50 && rxn(0) == 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (rxn(0) != 1 || cnt[0] !== 16'd1 || viol[0] != base)
            $display("FAIL rst_after: bytes=%0d cnt=%0d hs_breaks=%0d required 1 1 0", rxn(0), cnt[0], viol[0] - base);
        else n_pass++;
        if (rxn(0) > 0) begin
            n_checks++;
            if (rxb(0, 0) !== 8'h55) $display("FAIL rst_byte: got %h required 55", rxb(0, 0));
            else n_pass++;
        end
    endtask

    task automatic test_wrap;
        logic [7:0] b;
        do_reset;
        tlen[0] = 2;
        wait_idle(0);
        force u0.cnt_q = 16'hFFFF;
        @(negedge clk);
        release u0.cnt_q;
        @(negedge clk);
        n_checks++;
        if (cnt[0] !== 16'hFFFF) $display("FAIL wrap_pre: cnt=%h required ffff", cnt[0]);
        else n_pass++;
        clr_log(0);
        b = 8'($urandom);
        req_wr[0] = 4'b1000; req_data[0] = {b, 24'h0};
        @(negedge clk);
        req_wr[0] = '0;
        for (int t = 0; t < 50 && rxn(0) == 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (cnt[0] !== 16'h0000) $display("FAIL wrap: cnt=%h required 0000", cnt[0]);
        else n_pass++;
        n_checks++;
        if (rxn(0) != 1 || rxb(0, 0) !== b) $display("FAIL wrap_byte: bytes=%0d first=%h required 1 %h", rxn(0), rxb(0, 0), b);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_wr[0] = '0; req_wr[1] = '0;
        req_data[0] = '0; req_data[1] = '0;
        test_reset;
        test_single;
        test_all_at_once;
        test_saturate(0, 4'b1111, 6, 100);
        test_saturate(0, 4'b1001, 8, 100);
        test_saturate(0, 4'b1111, 8, 40);
        test_tag;
        test_saturate(1, 4'b1111, 4, 100);
        test_reset_mid;
        test_wrap;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
